// File: rtl/irq_pending_latch.sv
// Interrupt front end: synchronises eight request lines, latches them into a masked
// pending vector for the priority encoder and handshakes with the host. IRQ_OVERRUN_EN adds ovr_flag.
module irq_pending_latch #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE_MODE   = 1,
    parameter int unsigned HOLDOFF     = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] irq_in,
    input  logic       mask_wr,
    input  logic [7:0] mask_data,
    output logic [7:0] pend_vec,
    output logic       irq_req,
    input  logic       irq_ack,
    input  logic [2:0] ack_idx,
    output logic       ack_err
`ifdef IRQ_OVERRUN_EN
    ,
    output logic [7:0] ovr_flag
`endif
);

    localparam int unsigned NUM_IRQ = 8;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HOLD   = 2'd2
    } state_e;

    logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q;
    logic [NUM_IRQ-1:0] sync_s;
    logic [NUM_IRQ-1:0] prev_q;
    logic [NUM_IRQ-1:0] set_c;
    logic [NUM_IRQ-1:0] clr_c;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] mask_q;
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               irq_req_q;
    logic               ack_err_q, ack_err_d;

    assign sync_s   = sync_q[SYNC_STAGES-1];
    assign set_c    = (EDGE_MODE != 0) ? (sync_s & ~prev_q) : sync_s;
    assign pend_vec = pending_q & ~mask_q;
    assign irq_req  = irq_req_q;
    assign ack_err  = ack_err_q;

    // Synchroniser chain, edge history, pending and mask registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            prev_q    <= '0;
            pending_q <= '0;
            mask_q    <= '0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], irq_in};
            prev_q    <= sync_s;
            pending_q <= pending_d;
            if (mask_wr) begin
                mask_q <= mask_data;
            end
        end
    end

    // A capture in the same cycle as its own clear re-pends the bit
    always_comb begin
        pending_d = (pending_q & ~clr_c) | set_c;
    end

    // Request FSM state, hold-off counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            irq_req_q <= 1'b0;
            ack_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            irq_req_q <= (state_d == ACTIVE);
            ack_err_q <= ack_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ack_err_d = 1'b0;
        clr_c     = '0;
        case (state_q)
            IDLE: begin
                if (irq_ack) begin
                    ack_err_d = 1'b1;
                end
                if (pend_vec != '0) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (irq_ack) begin
                    if (pend_vec[ack_idx]) begin
                        clr_c = NUM_IRQ'(1) << ack_idx;
                        if (HOLDOFF == 0) begin
                            state_d = IDLE;
                        end else begin
                            state_d = HOLD;
                            cnt_d   = CNT_W'(HOLDOFF);
                        end
                    end else begin
                        ack_err_d = 1'b1;
                    end
                end else if (pend_vec == '0) begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (irq_ack) begin
                    ack_err_d = 1'b1;
                end
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef IRQ_OVERRUN_EN
    logic [NUM_IRQ-1:0] ovr_q, ovr_d;

    // Lost interrupt: a new capture lands on a bit that is still pending
    always_comb begin
        ovr_d = (ovr_q & ~clr_c) | (set_c & pending_q & ~clr_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_q <= '0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign ovr_flag = ovr_q;
`endif

endmodule

// File: doc/irq_pending_latch.md
Name: irq_pending_latch

Overview:
- Upstream stage of the 8-bit priority encoder.
- Synchronises eight asynchronous interrupt request lines and captures each one (edge or level) into a pending register.
- Applies a software mask and presents the 8-bit pending vector as the encoder's D input.
- Raises a request to the host; the host acknowledges with the 3-bit index produced by the encoder, and the block clears that pending bit and runs a hold-off interval.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops per irq line (legal 2..4).
- EDGE_MODE, 1, 1 = capture on rising edge; 0 = level capture (pending set every cycle the synced line is high).
- HOLDOFF, 2, cycles irq_req stays low after an accepted ack (legal 0..15).

Ports:
- clk, input, 1, single clock; all state updates on posedge.
- rst_n, input, 1, asynchronous active-low reset.
- irq_in, input, 8, raw asynchronous request lines; bit 7 is highest priority downstream.
- mask_wr, input, 1, one-cycle strobe that loads mask_data into the mask register.
- mask_data, input, 8, mask value; 1 = source masked.
- pend_vec, output, 8, pending & ~mask; drives encoder D.
- irq_req, output, 1, interrupt request to host.
- irq_ack, input, 1, host acknowledge strobe (one cycle).
- ack_idx, input, 3, index being acknowledged (the encoder y value the host sampled).
- ack_err, output, 1, one-cycle pulse on an illegal ack.

Behaviour:
- Reset: async assert, sync-release use assumed by the system.
  - Synchroniser flops, edge-history flops, pending, mask, state and hold-off counter all go to 0; FSM goes to IDLE.
  - Outputs: pend_vec=8'h00, irq_req=0, ack_err=0.
  - Reset mid-service discards all pending state and returns to IDLE.
- Synchroniser: each irq_in bit passes through SYNC_STAGES flops. Call the result s[i] and its previous value p[i].
- Capture:
  - set[i] = s[i] & ~p[i] when EDGE_MODE=1; set[i] = s[i] when EDGE_MODE=0.
  - Latency from an irq_in rising edge (meeting setup) to the pending bit being visible on pend_vec is SYNC_STAGES+1 clocks.
- Pending update, every clock: pending[i] <= (pending[i] & ~clr[i]) | set[i].
  - Set wins over clear in the same cycle, so a new edge coincident with its own ack re-pends the bit.
- clr[i] is 1 only on an accepted ack where ack_idx==i.
- Mask:
  - mask_wr loads the mask on the next edge.
  - Masked bits still latch into pending but are hidden from pend_vec.
  - Unmasking exposes them on the following cycle.
  - pend_vec is combinational from the pending and mask registers; there is no extra latency.
- FSM states: IDLE, ACTIVE, HOLD.
  - IDLE: irq_req=0. Go to ACTIVE when pend_vec != 0.
  - ACTIVE: irq_req=1.
    - irq_ack with pend_vec[ack_idx]==1: accepted; clear that bit. Go to HOLD with counter=HOLDOFF, or to IDLE if HOLDOFF==0.
    - irq_ack with pend_vec[ack_idx]==0: rejected; ack_err pulses next cycle; state unchanged.
    - No ack and pend_vec becomes 0 (for example, a mask write): go to IDLE; irq_req drops the next cycle.
  - HOLD: irq_req=0. The counter decrements each cycle; at 1 go to IDLE. Captures continue during HOLD.
- irq_ack in IDLE or HOLD: ignored; ack_err pulses.
- irq_req is a registered output: high exactly while the state is ACTIVE.
- ack_idx is sampled only when irq_ack=1.

Optional Feature:
- Macro: IRQ_OVERRUN_EN.
- Defined:
  - Adds output port ovr_flag[7:0].
  - ovr_flag[i] is set when set[i]=1 while pending[i] is already 1 and not being cleared that cycle (a lost interrupt).
  - ovr_flag[i] is cleared on an accepted ack of i.
  - It resets to 0 and is masked by nothing.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Test Plan:
- Single edge, EDGE_MODE=1, SYNC_STAGES=2, mask=0:
  - Pulse irq_in[5] -> pend_vec=8'h20 after 3 clocks; irq_req=1 one clock later.
  - ack_idx=5 -> pend_vec=8'h00, irq_req=0, and it stays 0 for HOLDOFF=2 cycles, then IDLE.
- Multiple pending: edges on bits 1, 4 and 7 together -> pend_vec=8'h92.
  - Ack 7 -> 8'h12; after hold-off irq_req=1 again.
  - Ack 4 -> 8'h02; ack 1 -> 8'h00.
- Mask:
  - Write mask=8'h80, then edge on bit 7 -> pend_vec=8'h00 and irq_req stays 0.
  - Write mask=8'h00 -> pend_vec=8'h80 next cycle; irq_req=1.
- Bad ack:
  - In ACTIVE with pend_vec=8'h08, irq_ack with ack_idx=2 -> ack_err one-cycle pulse; pend_vec stays 8'h08.
  - irq_ack in IDLE -> ack_err pulse.
- Coincident set/clear: a new synced edge on bit 3 in the same cycle as an accepted ack of 3 -> bit 3 remains 1. With IRQ_OVERRUN_EN, a second edge while pending -> ovr_flag[3]=1, cleared by the next ack of 3.
- Reset mid-ACTIVE: drop rst_n with pend_vec=8'h41 -> immediately pend_vec=0, irq_req=0, ack_err=0; after release, no spurious capture while irq_in stays low.
